// File: rtl/asrv32_mem_arbiter_pkg.sv
//============================================================================
// Module : asrv32_mem_arbiter_pkg
// Brief  : Shared encodings for the two-requester memory arbiter.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package asrv32_mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GNT_D = 2'd1;
    localparam logic [1:0] ARB_GNT_I = 2'd2;

    localparam int GNT_BIT_D = 0;
    localparam int GNT_BIT_I = 1;

    localparam logic [3:0] SEL_WORD = 4'b1111;

    localparam logic WINNER_D = 1'b0;
    localparam logic WINNER_I = 1'b1;

endpackage

`default_nettype wire

// File: rtl/asrv32_rr_arbiter2.sv
//============================================================================
// Module : asrv32_rr_arbiter2
// Brief  : Combinational 2-way round-robin pick between D and I requesters.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module asrv32_rr_arbiter2
    import asrv32_mem_arbiter_pkg::*;
(
    input  logic req_d,
    input  logic req_i,
    input  logic last_winner,
    output logic pick_d,
    output logic pick_i
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        pick_d = req_d && (!req_i || (last_winner == WINNER_I));
        pick_i = req_i && !pick_d;
    end

endmodule

`default_nettype wire

// File: rtl/asrv32_mem_arbiter.sv
//============================================================================
// Module : asrv32_mem_arbiter
// Brief  : Wishbone-classic arbiter sharing one memory port between fetch (I)
//          and memory-access (D); one outstanding transaction at a time.
//          Optional bus timeout enabled by ASRV32_MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module asrv32_mem_arbiter
    import asrv32_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stb_d,
    input  logic              i_we_d,
    input  logic [ADDR_W-1:0] i_addr_d,
    input  logic [DATA_W-1:0] i_wdata_d,
    input  logic [3:0]        i_sel_d,
    output logic              o_ack_d,
    output logic [DATA_W-1:0] o_rdata_d,
    output logic              o_err_d,
    input  logic              i_stb_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              o_ack_i,
    output logic [DATA_W-1:0] o_rdata_i,
    output logic              o_err_i,
    output logic              o_stb,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic [3:0]        o_sel,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        o_grant
);

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              last_winner;
    logic              last_winner_nxt;
    logic              pick_d;
    logic              pick_i;
    logic              expire;

    logic              stb_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [3:0]        sel_nxt;
    logic [1:0]        grant_nxt;
    logic              ack_d_nxt;
    logic              ack_i_nxt;
    logic              err_d_nxt;
    logic              err_i_nxt;
    logic [DATA_W-1:0] rdata_d_nxt;
    logic [DATA_W-1:0] rdata_i_nxt;

    // Reset asserts asynchronously but releases only on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    asrv32_rr_arbiter2 u_rr (
        .req_d       (i_stb_d),
        .req_i       (i_stb_i),
        .last_winner (last_winner),
        .pick_d      (pick_d),
        .pick_i      (pick_i)
    );

`ifdef ASRV32_MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n)                tmo_cnt <= '0;
        else if (state == ARB_IDLE) tmo_cnt <= '0;
        else                       tmo_cnt <= tmo_cnt + 1'b1;
    end

    // An ack arriving on the expiry cycle takes precedence over the abort.
    assign expire = (state != ARB_IDLE) && !i_ack &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No timeout: a negative limit can never be reached, so this stays low.
    assign expire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            last_winner <= WINNER_I;
            o_stb       <= 1'b0;
            o_we        <= 1'b0;
            o_addr      <= '0;
            o_wdata     <= '0;
            o_sel       <= '0;
            o_grant     <= '0;
            o_ack_d     <= 1'b0;
            o_ack_i     <= 1'b0;
            o_err_d     <= 1'b0;
            o_err_i     <= 1'b0;
            o_rdata_d   <= '0;
            o_rdata_i   <= '0;
        end else begin
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
            o_stb       <= stb_nxt;
            o_we        <= we_nxt;
            o_addr      <= addr_nxt;
            o_wdata     <= wdata_nxt;
            o_sel       <= sel_nxt;
            o_grant     <= grant_nxt;
            o_ack_d     <= ack_d_nxt;
            o_ack_i     <= ack_i_nxt;
            o_err_d     <= err_d_nxt;
            o_err_i     <= err_i_nxt;
            o_rdata_d   <= rdata_d_nxt;
            o_rdata_i   <= rdata_i_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE: begin
                if (pick_d)      state_nxt = ARB_GNT_D;
                else if (pick_i) state_nxt = ARB_GNT_I;
            end
            ARB_GNT_D,
            ARB_GNT_I: begin
                if (i_ack || expire) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Bus fields are only loaded from IDLE, so they hold for the whole grant.
    always_comb begin
        last_winner_nxt = last_winner;
        stb_nxt         = o_stb;
        we_nxt          = o_we;
        addr_nxt        = o_addr;
        wdata_nxt       = o_wdata;
        sel_nxt         = o_sel;
        grant_nxt       = o_grant;
        ack_d_nxt       = 1'b0;
        ack_i_nxt       = 1'b0;
        err_d_nxt       = 1'b0;
        err_i_nxt       = 1'b0;
        rdata_d_nxt     = o_rdata_d;
        rdata_i_nxt     = o_rdata_i;
        case (state)
            ARB_IDLE: begin
                if (pick_d) begin
                    stb_nxt              = 1'b1;
                    we_nxt               = i_we_d;
                    addr_nxt             = i_addr_d;
                    wdata_nxt            = i_wdata_d;
                    sel_nxt              = i_sel_d;
                    grant_nxt            = '0;
                    grant_nxt[GNT_BIT_D] = 1'b1;
                end else if (pick_i) begin
                    stb_nxt              = 1'b1;
                    we_nxt               = 1'b0;
                    addr_nxt             = i_addr_i;
                    wdata_nxt            = '0;
                    sel_nxt              = SEL_WORD;
                    grant_nxt            = '0;
                    grant_nxt[GNT_BIT_I] = 1'b1;
                end
            end
            ARB_GNT_D: begin
                if (i_ack || expire) begin
                    stb_nxt         = 1'b0;
                    grant_nxt       = '0;
                    last_winner_nxt = WINNER_D;
                    ack_d_nxt       = i_ack;
                    err_d_nxt       = !i_ack;
                    if (i_ack) rdata_d_nxt = i_rdata;
                end
            end
            ARB_GNT_I: begin
                if (i_ack || expire) begin
                    stb_nxt         = 1'b0;
                    grant_nxt       = '0;
                    last_winner_nxt = WINNER_I;
                    ack_i_nxt       = i_ack;
                    err_i_nxt       = !i_ack;
                    if (i_ack) rdata_i_nxt = i_rdata;
                end
            end
            default: begin
                stb_nxt   = 1'b0;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_asrv32_mem_arbiter.sv
//============================================================================
// Module : tb_asrv32_mem_arbiter
// Brief  : Directed self-checking bench for asrv32_mem_arbiter (covers the
//          ASRV32_MEM_ARB_TIMEOUT_EN build when that macro is defined).
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_asrv32_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stb_d, we_d, ack_d, err_d;
    logic [31:0] addr_d, wdata_d, rdata_d;
    logic [3:0]  sel_d;
    logic        stb_i, ack_i, err_i;
    logic [31:0] addr_i, rdata_i;
    logic        stb, we, ack;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  sel;
    logic [1:0]  grant;

    int tests = 0;
    int fails = 0;

    asrv32_mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_stb_d   (stb_d),
        .i_we_d    (we_d),
        .i_addr_d  (addr_d),
        .i_wdata_d (wdata_d),
        .i_sel_d   (sel_d),
        .o_ack_d   (ack_d),
        .o_rdata_d (rdata_d),
        .o_err_d   (err_d),
        .i_stb_i   (stb_i),
        .i_addr_i  (addr_i),
        .o_ack_i   (ack_i),
        .o_rdata_i (rdata_i),
        .o_err_i   (err_i),
        .o_stb     (stb),
        .o_we      (we),
        .o_addr    (addr),
        .o_wdata   (wdata),
        .o_sel     (sel),
        .i_ack     (ack),
        .i_rdata   (rdata),
        .o_grant   (grant)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        rst_n = 1'b0; stb_d = 0; we_d = 0; addr_d = '0; wdata_d = '0; sel_d = 4'b1111;
        stb_i = 0; addr_i = '0; ack = 0; rdata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_stb", stb, 0);
        check("rst_grant", grant, 2'b00);
        check("rst_ack_d", ack_d, 0);
        check("rst_addr", addr, 0);
        rst_n = 1'b1;
        repeat (4) tick();

        // D load
        stb_d = 1; addr_d = 32'h100;
        tick();
        check("ld_stb", stb, 1);
        check("ld_addr", addr, 32'h100);
        check("ld_grant", grant, 2'b01);
        check("ld_we", we, 0);
        tick();
        check("ld_wait_stb", stb, 1);
        ack = 1; rdata = 32'hDEADBEEF;
        tick();
        check("ld_ack_d", ack_d, 1);
        check("ld_rdata_d", rdata_d, 32'hDEADBEEF);
        check("ld_stb_low", stb, 0);
        check("ld_grant_idle", grant, 2'b00);
        stb_d = 0; ack = 0;
        tick();
        check("ld_ack_pulse", ack_d, 0);
        check("ld_rdata_hold", rdata_d, 32'hDEADBEEF);

        // Contention after reset: D first, then I
        apply_reset();
        stb_d = 1; addr_d = 32'h200; stb_i = 1; addr_i = 32'h300;
        tick();
        check("rr1_grant", grant, 2'b01);
        check("rr1_addr", addr, 32'h200);
        ack = 1; rdata = 32'h11111111;
        tick();
        check("rr1_ack_d", ack_d, 1);
        check("rr1_ack_i", ack_i, 0);
        stb_d = 0; ack = 0;
        tick();
        check("rr2_grant", grant, 2'b10);
        check("rr2_addr", addr, 32'h300);
        check("if_we", we, 0);
        check("if_sel", sel, 4'b1111);
        addr_i = 32'h304;
        tick();
        check("if_addr_hold", addr, 32'h300);
        ack = 1; rdata = 32'h22222222;
        tick();
        check("rr2_ack_i", ack_i, 1);
        check("rr2_rdata_i", rdata_i, 32'h22222222);
        check("rr2_ack_d", ack_d, 0);
        check("rr2_rdata_d_hold", rdata_d, 32'h11111111);
        ack = 0; stb_d = 1; addr_d = 32'h208;
        // Both held continuously: strict alternation D, I, D
        tick();
        check("alt1_grant", grant, 2'b01);
        ack = 1;
        tick();
        check("alt1_ack_d", ack_d, 1);
        ack = 0;
        tick();
        check("alt2_grant", grant, 2'b10);
        check("alt2_addr", addr, 32'h304);
        ack = 1;
        tick();
        check("alt2_ack_i", ack_i, 1);
        ack = 0;
        tick();
        check("alt3_grant", grant, 2'b01);
        ack = 1;
        tick();
        check("alt3_ack_d", ack_d, 1);
        ack = 0; stb_d = 0; stb_i = 0;
        tick();

        // D store with wait states; bus fields must not follow input changes
        stb_d = 1; we_d = 1; sel_d = 4'b0100; wdata_d = 32'h00AB0000; addr_d = 32'h400;
        tick();
        check("st_we", we, 1);
        check("st_sel", sel, 4'b0100);
        check("st_wdata", wdata, 32'h00AB0000);
        wdata_d = 32'hFFFFFFFF; sel_d = 4'b1111; addr_d = 32'h500; we_d = 0;
        for (int w = 0; w < 5; w++) begin
            tick();
            check("st_wait_wdata", wdata, 32'h00AB0000);
            check("st_wait_sel", sel, 4'b0100);
            check("st_wait_addr", addr, 32'h400);
        end
        ack = 1;
        tick();
        check("st_ack_d", ack_d, 1);
        ack = 0; stb_d = 0;
        tick();

        // Requester drops stb mid-grant; ack still delivered
        stb_i = 1; addr_i = 32'h600;
        tick();
        check("drop_grant", grant, 2'b10);
        stb_i = 0;
        tick();
        check("drop_stb_held", stb, 1);
        ack = 1; rdata = 32'h33333333;
        tick();
        check("drop_ack_i", ack_i, 1);
        check("drop_err_i", err_i, 0);
        check("drop_rdata_i", rdata_i, 32'h33333333);

        // Ack while idle is ignored (ack kept high for this cycle)
        tick();
        check("idle_ack_d", ack_d, 0);
        check("idle_ack_i", ack_i, 0);
        check("idle_stb", stb, 0);
        ack = 0;
        tick();

        // Timeout behaviour (last winner is I, so D alone is granted)
        stb_d = 1; addr_d = 32'h700;
        tick();
        check("to_grant", grant, 2'b01);
`ifdef ASRV32_MEM_ARB_TIMEOUT_EN
        repeat (3) tick();
        check("to_stb_before", stb, 1);
        tick();
        check("to_stb_abort", stb, 0);
        check("to_err_d", err_d, 1);
        check("to_no_ack_d", ack_d, 0);
        check("to_grant_idle", grant, 2'b00);
        stb_d = 0;
        tick();
        check("to_err_pulse", err_d, 0);
        // Ack on the expiry cycle wins
        stb_i = 1; addr_i = 32'h800;
        tick();
        check("tox_grant", grant, 2'b10);
        repeat (3) tick();
        ack = 1; rdata = 32'h44444444;
        tick();
        check("tox_ack_i", ack_i, 1);
        check("tox_err_i", err_i, 0);
        ack = 0; stb_i = 0;
        tick();
`else
        repeat (10) tick();
        check("nto_stb_held", stb, 1);
        check("nto_err_d", err_d, 0);
        ack = 1;
        tick();
        check("nto_ack_d", ack_d, 1);
        ack = 0; stb_d = 0;
        tick();
`endif

        // Reset during GNT_I, then D wins contention after release
        stb_i = 1; addr_i = 32'h900;
        tick();
        check("rg_grant_i", grant, 2'b10);
        rst_n = 1'b0;
        #1;
        check("rg_stb_now", stb, 0);
        check("rg_grant_now", grant, 2'b00);
        tick();
        check("rg_ack_i", ack_i, 0);
        check("rg_err_i", err_i, 0);
        stb_d = 1; addr_d = 32'hA00;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("rg_d_wins", grant, 2'b01);
        check("rg_addr", addr, 32'hA00);
        ack = 1;
        tick();
        check("rg_ack_d", ack_d, 1);
        ack = 0; stb_d = 0; stb_i = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
